// File: rtl/gf_red_pkg.sv
// Shared types and helpers for the GF(2^m) reduction scheduler.
package gf_red_pkg;

    typedef enum logic [1:0] {
        CFG_WAIT,
        RUN,
        DRAIN
    } state_t;

    function automatic int tag_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int grade_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic logic grade_legal(input int unsigned grade, input int unsigned dw);
        return (grade >= 32'd2) && (grade <= dw);
    endfunction

endpackage

// File: rtl/gf_res_fifo.sv
// Synchronous result FIFO with occupancy count; head is shown combinationally.
module gf_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gf_red_sched.sv
// Round-robin scheduler feeding one external 2-cycle GF(2^m) reduction unit,
// with tagged in-flight tracking and a credit-protected result FIFO.
module gf_red_sched
    import gf_red_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RED_LAT    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [grade_w(DATA_WIDTH)-1:0]        cfg_grade,
    input  logic [DATA_WIDTH:0]                   cfg_poly,
    output logic                                  cfg_err,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]       req_data,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic [tag_w(NUM_REQ)-1:0]             rsp_id,
    output logic                                  red_enable,
    output logic [grade_w(DATA_WIDTH)-1:0]        red_grade,
    output logic [DATA_WIDTH:0]                   red_poly,
    output logic [2*DATA_WIDTH-1:0]               red_in,
    input  logic [DATA_WIDTH-1:0]                 red_out
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int GW    = grade_w(DATA_WIDTH);
    localparam int OPW   = 2 * DATA_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    state_t             state, state_nxt;
    logic [GW-1:0]      grade_q;
    logic [DATA_WIDTH:0] poly_q;
    logic               err_q;
    logic [TAG_W-1:0]   rr_ptr;
    logic               pipe_vld [RED_LAT];
    logic [TAG_W-1:0]   pipe_tag [RED_LAT];
    int unsigned        inflight;
    int unsigned        arb_idx;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_found;
    logic               credit_ok;
    logic               issue;
    logic               cfg_hs;
    logic               cfg_legal;

    assign cfg_hs    = cfg_valid && cfg_ready;
    assign cfg_legal = grade_legal(32'(cfg_grade), DATA_WIDTH);
    assign red_grade = grade_q;
    assign red_poly  = poly_q;
    assign cfg_err   = err_q;

    always_comb begin
        inflight = 0;
        for (int unsigned k = 0; k < RED_LAT; k++) inflight = inflight + 32'(pipe_vld[k]);
    end

    // Credit counts in-flight ops as already occupying FIFO slots, so overflow is impossible.
    assign credit_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            arb_idx = 32'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!grant_found && req_valid[arb_idx[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = arb_idx[TAG_W-1:0];
            end
        end
    end

    assign issue = (state == RUN) && !cfg_valid && grant_found && credit_ok;

    always_comb begin
        req_ready = '0;
        red_in    = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            red_in = req_data[32'(grant_idx)*OPW +: OPW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CFG_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_WAIT: if (cfg_hs) state_nxt = cfg_legal ? RUN : CFG_WAIT;
            RUN:      if (cfg_valid) state_nxt = DRAIN;
            DRAIN:    if (cfg_hs) state_nxt = cfg_legal ? RUN : CFG_WAIT;
            default:  state_nxt = CFG_WAIT;
        endcase
    end

    always_comb begin
        cfg_ready  = 1'b0;
        red_enable = 1'b0;
        case (state)
            CFG_WAIT: cfg_ready = 1'b1;
            RUN:      red_enable = 1'b1;
            DRAIN: begin
                red_enable = 1'b1;
                cfg_ready  = (inflight == 0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grade_q <= '0;
            poly_q  <= '0;
            err_q   <= 1'b0;
            rr_ptr  <= TAG_W'(NUM_REQ - 1);
        end else begin
            if (cfg_hs) begin
                grade_q <= cfg_grade;
                poly_q  <= cfg_poly;
                err_q   <= !cfg_legal;
            end
            if (issue) rr_ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < RED_LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_tag[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_tag[0] <= grant_idx;
            for (int unsigned k = 1; k < RED_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    gf_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TAG_W + DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_vld[RED_LAT-1]),
        .push_data ({pipe_tag[RED_LAT-1], red_out}),
        .pop       (rsp_valid && rsp_ready),
        .head      ({rsp_id, rsp_data}),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_gf_red_sched.sv
// Bench for gf_red_sched: external reduction-unit model, scoreboard and directed/random tests.
module tb_gf_red_sched;

    localparam int DW = 10;
    localparam int NR = 4;
    localparam int FD = 4;
    localparam int RL = 2;
    localparam int TW = 2;
    localparam int GW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [GW-1:0]     cfg_grade;
    logic [DW:0]       cfg_poly;
    logic              cfg_err;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*2*DW-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_id;
    logic              red_enable;
    logic [GW-1:0]     red_grade;
    logic [DW:0]       red_poly;
    logic [2*DW-1:0]   red_in;
    logic [DW-1:0]     red_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_red_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .FIFO_DEPTH (FD),
        .RED_LAT    (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_grade  (cfg_grade),
        .cfg_poly   (cfg_poly),
        .cfg_err    (cfg_err),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .red_enable (red_enable),
        .red_grade  (red_grade),
        .red_poly   (red_poly),
        .red_in     (red_in),
        .red_out    (red_out)
    );

    // Polynomial remainder by long division over GF(2).
    function automatic logic [DW-1:0] gf_mod(input logic [2*DW-1:0] x, input logic [GW-1:0] g,
                                             input logic [DW:0] p);
        logic [2*DW-1:0] r;
        logic [2*DW-1:0] pp;
        r  = x;
        pp = {{(DW-1){1'b0}}, p};
        if (g == '0) return r[DW-1:0];
        for (int b = 2*DW-1; b >= int'(g); b--)
            if (r[b]) r = r ^ (pp << (b - int'(g)));
        return r[DW-1:0];
    endfunction

    // External reduction unit: two registers, synchronous clear while enable is low.
    logic [DW-1:0] s1, s2;
    always_ff @(posedge clk) begin
        if (!red_enable) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gf_mod(red_in, red_grade, red_poly);
            s2 <= s1;
        end
    end
    assign red_out = s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] id;
    } rsp_t;

    rsp_t        sb[$];
    int          mode;          // 0 waiting for config, 1 running, 2 draining
    logic        merr;
    logic [GW-1:0] mgrade;
    logic [DW:0] mpoly;
    int          mptr;
    int          d1, d2;        // issues one and two cycles ago
    logic        hold_prev;
    logic [DW-1:0] hold_data;
    logic [TW-1:0] hold_id;

    always @(negedge clk) begin : monitor
        int   exp_grant, j;
        logic found, exp_issue, exp_cr, legal;
        rsp_t front;
        if (!rst_n) begin
            sb.delete();
            mode = 0; merr = 1'b0; mgrade = '0; mpoly = '0;
            mptr = NR - 1; d1 = 0; d2 = 0; hold_prev = 1'b0;
        end else begin
            found = 1'b0; exp_grant = 0;
            for (int k = 1; k <= NR; k++) begin
                j = (mptr + k) % NR;
                if (!found && req_valid[j]) begin
                    found = 1'b1;
                    exp_grant = j;
                end
            end
            exp_issue = (mode == 1) && !cfg_valid && found && (sb.size() < FD);
            check("grant", 32'(req_ready), exp_issue ? (32'd1 << exp_grant) : 32'd0);
            check("red_in", 32'(red_in), exp_issue ? 32'(req_data[exp_grant*2*DW +: 2*DW]) : 32'd0);
            check("red_enable", 32'(red_enable), 32'(mode != 0));
            exp_cr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((d1 + d2) == 0);
            check("cfg_ready", 32'(cfg_ready), 32'(exp_cr));
            check("cfg_err", 32'(cfg_err), 32'(merr));
            check("red_grade", 32'(red_grade), 32'(mgrade));
            check("red_poly", 32'(red_poly), 32'(mpoly));
            if (hold_prev) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_data", 32'({rsp_id, rsp_data}), 32'({hold_id, hold_data}));
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            hold_id   = rsp_id;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    front = sb.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(front.data));
                    check("rsp_id", 32'(rsp_id), 32'(front.id));
                end
            end
            if (exp_issue) begin
                sb.push_back({gf_mod(req_data[exp_grant*2*DW +: 2*DW], mgrade, mpoly), TW'(exp_grant)});
                mptr = exp_grant;
            end
            d2 = d1;
            d1 = exp_issue ? 1 : 0;
            if (cfg_valid && exp_cr) begin
                legal  = (cfg_grade >= 2) && (cfg_grade <= DW);
                mgrade = cfg_grade;
                mpoly  = cfg_poly;
                merr   = !legal;
                mode   = legal ? 1 : 0;
            end else if (mode == 1 && cfg_valid) begin
                mode = 2;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_cfg(input logic [GW-1:0] g, input logic [DW:0] p);
        logic ok;
        cfg_grade = g;
        cfg_poly  = p;
        cfg_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cfg_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_one(input int r, input logic [2*DW-1:0] op, input logic [DW-1:0] expv);
        logic ok;
        int   hs;
        rsp_ready = 1'b1;
        req_data[r*2*DW +: 2*DW] = op;
        req_valid = NR'(1 << r);
        ok = 1'b0; hs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1'b1;
                hs = cyc;
                break;
            end
        end
        check("req_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_timeout", 32'(ok), 32'd1);
        check("latency", 32'(cyc - hs), 32'd3);
        check("vec_data", 32'(rsp_data), 32'(expv));
        check("vec_id", 32'(rsp_id), 32'(r));
        @(posedge clk); #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) req_data[i*2*DW +: 2*DW] = (2*DW)'($urandom);
    endtask

    typedef struct {
        logic [GW-1:0]   grade;
        logic [DW:0]     poly;
        int              req;
        logic [2*DW-1:0] operand;
        logic [DW-1:0]   expected;
    } vec_t;

    typedef struct {
        logic [GW-1:0] grade;
        logic [DW:0]   poly;
    } cfg_t;

    vec_t vecs[8];
    cfg_t cfgs[5];
    logic [GW-1:0] bad_grades[4];

    initial begin
        int n, m, stale;
        vecs[0] = '{5'd4,  11'h013, 0, 20'h00040, 10'h00C};
        vecs[1] = '{5'd4,  11'h013, 1, 20'h00010, 10'h003};
        vecs[2] = '{5'd4,  11'h013, 2, 20'h0000F, 10'h00F};
        vecs[3] = '{5'd8,  11'h11B, 3, 20'h00100, 10'h01B};
        vecs[4] = '{5'd8,  11'h11B, 0, 20'h00200, 10'h036};
        vecs[5] = '{5'd10, 11'h409, 1, 20'h00400, 10'h009};
        vecs[6] = '{5'd2,  11'h007, 2, 20'h00008, 10'h001};
        vecs[7] = '{5'd10, 11'h409, 3, 20'h003FF, 10'h3FF};
        cfgs[0] = '{5'd4, 11'h013};
        cfgs[1] = '{5'd8, 11'h11B};
        cfgs[2] = '{5'd10, 11'h409};
        cfgs[3] = '{5'd2, 11'h007};
        cfgs[4] = '{5'd3, 11'h00B};
        bad_grades[0] = 5'd0;
        bad_grades[1] = 5'd1;
        bad_grades[2] = 5'd11;
        bad_grades[3] = 5'd31;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_grade = '0; cfg_poly = '0;
        req_valid = '1; req_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_red_enable", 32'(red_enable), 32'd0);
        check("rst_red_cfg", 32'({red_grade, red_poly}), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_red_in", 32'(red_in), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // single-op vectors across configurations and requesters
        foreach (vecs[i]) begin
            do_cfg(vecs[i].grade, vecs[i].poly);
            send_one(vecs[i].req, vecs[i].operand, vecs[i].expected);
        end

        // round-robin at full rate from a fresh pointer
        do_reset();
        do_cfg(5'd4, 11'h013);
        rsp_ready = 1'b1;
        req_valid = '1;
        rand_data();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rr_order", 32'(req_ready), 32'd1 << (k % NR));
            @(posedge clk); #1;
            rand_data();
        end
        req_valid = '0;
        repeat (6) @(posedge clk); #1;

        // back-pressure: credits exhaust after exactly FIFO_DEPTH issues
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[1]) n++;
            @(posedge clk); #1;
            rand_data();
        end
        check("bp_issue_count", 32'(n), 32'd4);
        @(negedge clk);
        check("bp_stalled", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        m = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) m++;
        end
        check("bp_rsp_count", 32'(m), 32'd4);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        check("bp_resume", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk); #1;

        // reconfigure while streaming
        req_valid = '1;
        repeat (5) begin
            rand_data();
            @(posedge clk); #1;
        end
        cfg_grade = 5'd8; cfg_poly = 11'h11B; cfg_valid = 1'b1;
        @(negedge clk);
        check("drain_stop", 32'(req_ready), 32'd0);
        check("drain_ready0", 32'(cfg_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_ready1", 32'(cfg_ready), 32'd0);
        check("drain_stop2", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_ready2", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        req_valid = '0;
        send_one(2, 20'h00100, 10'h01B);

        // illegal grades keep the block idle and set the sticky error
        foreach (bad_grades[i]) begin
            do_cfg(bad_grades[i], 11'h013);
            check("err_set", 32'(cfg_err), 32'd1);
            req_valid = '1;
            @(negedge clk);
            check("err_no_issue", 32'(req_ready), 32'd0);
            check("err_idle", 32'(red_enable), 32'd0);
            @(posedge clk); #1;
            req_valid = '0;
        end
        do_cfg(5'd4, 11'h013);
        @(negedge clk);
        check("err_clear", 32'(cfg_err), 32'd0);
        check("err_run", 32'(red_enable), 32'd1);
        @(posedge clk); #1;

        // asynchronous reset with a full FIFO and ops in flight
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (6) begin
            rand_data();
            @(posedge clk); #1;
        end
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_red_enable", 32'(red_enable), 32'd0);
        check("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        check("no_stale_rsp", 32'(stale), 32'd0);
        @(posedge clk); #1;

        // randomized traffic under several configurations
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 4);
            do_cfg(cfgs[n].grade, cfgs[n].poly);
            for (int k = 0; k < 150; k++) begin
                req_valid = NR'($urandom);
                rand_data();
                rsp_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_rsp_idle", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_red_sched.md
Name: gf_red_sched

Overview:
- Round-robin scheduler sharing one registered GF(2^m) reduction unit between NUM_REQ requesters.
- The reduction unit has 2-cycle latency, no stall and an active-low synchronous clear ("enable").
- Owns the field configuration (grade, primitive polynomial) and issues operands with valid/ready handshakes.
- Tags in-flight operations, buffers results in a credit-protected FIFO and returns them with the requester id.

Parameters:
- DATA_WIDTH, 10: field width m; must match the reduction unit.
- NUM_REQ, 4: number of requesters.
- FIFO_DEPTH, 4: result FIFO entries; must be at least RED_LAT.
- RED_LAT, 2: reduction unit latency in cycles.
- Derived: TAG_W = max(1, clog2(NUM_REQ)); GW = clog2(DATA_WIDTH)+1.

Ports:
- clk in 1: single clock.
- rst_n in 1: reset, asynchronous, active-low.
- cfg_valid in 1: configuration request.
- cfg_ready out 1: configuration accept.
- cfg_grade in GW: polynomial grade.
- cfg_poly in DATA_WIDTH+1: primitive polynomial.
- cfg_err out 1: sticky flag, illegal grade accepted.
- req_valid in NUM_REQ: per-requester operand valid.
- req_ready out NUM_REQ: one-hot grant.
- req_data in NUM_REQ*2*DATA_WIDTH: operands; requester i occupies slice [i*2DW +: 2DW].
- rsp_valid out 1: result valid.
- rsp_ready in 1: result accept.
- rsp_data out DATA_WIDTH: reduced value.
- rsp_id out TAG_W: originating requester.
- red_enable out 1: drives the reduction unit enable.
- red_grade out GW: drives the unit's polyn_grade.
- red_poly out DATA_WIDTH+1: drives the unit's polyn_red_in.
- red_in out 2*DATA_WIDTH: drives the unit's reduc_in.
- red_out in DATA_WIDTH: the unit's output.

Behaviour:
- Reset (async): state CFG_WAIT; FIFO empty; in-flight pipe cleared; RR pointer = NUM_REQ-1; config regs, cfg_err, red_* and req_ready all 0; rsp_valid 0; cfg_ready 1.
- FSM states: CFG_WAIT, RUN, DRAIN.
- CFG_WAIT:
  - cfg_ready=1, red_enable=0, no issue.
  - On cfg handshake, register grade/poly.
  - Grade in [2,DATA_WIDTH]: go to RUN, cfg_err=0. Otherwise stay in CFG_WAIT, cfg_err=1.
- RUN:
  - red_enable=1, cfg_ready=0.
  - A cycle with cfg_valid=1 goes to DRAIN; no issue in that cycle.
- DRAIN:
  - red_enable=1, no issue.
  - cfg_ready = (in-flight count == 0).
  - On handshake, apply the same legality rule as CFG_WAIT: legal goes to RUN, illegal goes to CFG_WAIT.
  - cfg_valid must be held until accepted.
- red_grade/red_poly come from config regs only; they change only while nothing is in flight.
- Issue occurs when state==RUN, |req_valid, and (fifo_count + inflight) < FIFO_DEPTH.
  - Grant: first requester with valid set, searching from pointer+1 with wrap.
  - req_ready is one-hot on the granted requester; the pointer moves to the granted index.
  - red_in = granted operand; red_in = 0 when not issuing.
- Tag pipe: RED_LAT-stage shift register of {valid, tag}, loaded on issue.
  - When the tail is valid, red_out is pushed into the FIFO with the tail's tag that cycle.
- Latency: the result is visible on rsp_* exactly RED_LAT+1 cycles after the req handshake cycle when the FIFO is empty.
- Throughput: 1 operation per cycle sustained.
- FIFO ordering: results in issue order.
- FIFO push and pop in the same cycle are allowed; count is unchanged.
- rsp_data/rsp_id are held stable while rsp_valid && !rsp_ready.
- Credit rule guarantees no FIFO overflow. Results drain in every state.
- Reset mid-operation drops all in-flight operations and FIFO contents.

Decomposition:
- Package gf_red_pkg:
  - State enum {CFG_WAIT, RUN, DRAIN}.
  - TAG_W and GW helper functions.
  - Grade-legality function.
- Sub-module gf_res_fifo: synchronous FIFO, parameterised depth and width, count output.
- Arbiter and tag pipe stay inline.
- The reduction unit is instantiated outside and connected via the red_* ports.

Test Plan:
1. Reset, then config grade=4, poly=0x013. Req0 sends 0x00040 -> rsp_data=0x00C, rsp_id=0, rsp_valid exactly 3 cycles after the handshake.
2. All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1,… at one per cycle; rsp_id follows the same order.
3. rsp_ready=0, req1 streaming -> exactly 4 handshakes, then req_ready=0. Raise rsp_ready -> 4 in-order responses, then issue resumes.
4. Stream under grade 4, then cfg grade=8 poly=0x11B -> issue stops immediately; cfg_ready rises once 2 in-flight ops complete. Next op 0x00100 -> 0x01B.
5. Config grade=1 -> cfg_err=1, stays in CFG_WAIT, req_ready=0. Then config grade=4 -> cfg_err=0, enters RUN.
6. Assert rst_n low mid-stream, asynchronously -> rsp_valid, req_ready, red_enable go to 0 immediately; no stale response after release.
